// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of uart_tx. Each queued byte is launched
// with a one-cycle start pulse. The launcher then waits for the transmitter's
// busy level to rise (bounded by ACK_TIMEOUT) and to fall again before it
// launches the next byte. Dropped writes and missing acknowledges are reported
// through sticky status bits.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                  i_clk_tx,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_ack_err,
  input  logic                  i_clr_status,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_busy
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_count, w_count_nxt;
  logic                    r_full, r_empty;
  logic                    r_overflow, r_ack_err;
  logic                    r_tx_start;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic [CW-1:0]           r_ack_cnt, w_ack_cnt_nxt;
  logic                    w_pop, w_wr_acc, w_ovf_set, w_ack_timeout;

  // A full FIFO can still take a write when the head leaves on the same edge.
  assign w_wr_acc  = i_wr_en && (!r_full || w_pop);
  assign w_ovf_set = i_wr_en && !w_wr_acc;

  // Occupancy after this edge; a write and a pop together cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk_tx) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and registered occupancy flags; pointers wrap naturally (DEPTH = 2**ADDR_WIDTH).
  always_ff @(posedge i_clk_tx or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (ADDR_WIDTH+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Launch sequencer next-state logic; pop happens only out of IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_ack_cnt_nxt = r_ack_cnt;
    w_pop         = 1'b0;
    w_ack_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && !i_tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_ack_cnt_nxt = CW'(ACK_TIMEOUT - 1);
        w_state_nxt   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (i_tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_ack_cnt == '0) begin
          // Byte is treated as consumed; no retry.
          w_ack_timeout = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt - CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, ack counter and launch outputs; data moves only on a launch.
  always_ff @(posedge i_clk_tx or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ack_cnt  <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack_cnt  <= w_ack_cnt_nxt;
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  // Sticky status; a clear pulse beats a coincident set.
  always_ff @(posedge i_clk_tx or posedge i_reset) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
      r_ack_err  <= 1'b0;
    end else if (i_clr_status) begin
      r_overflow <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      if (w_ovf_set)     r_overflow <= 1'b1;
      if (w_ack_timeout) r_ack_err  <= 1'b1;
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_ack_err  = r_ack_err;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based model of the buffer and launcher.
module tb_uart_tx_fifo;
  localparam int DW = 8, DEPTH = 16, AW = 4, ACK = 8;

  logic          clk = 1'b0;
  logic          rst, wr_en, clr, tx_busy;
  logic [DW-1:0] wr_data;
  logic          full, empty, ovf, ack_err, tx_start;
  logic [AW:0]   count;
  logic [DW-1:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ACK_TIMEOUT(ACK)) dut (
    .i_clk_tx(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(ovf),
    .o_ack_err(ack_err), .i_clr_status(clr), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .i_tx_busy(tx_busy));

  int n_checks = 0, n_errs = 0;

  // Model: queue of pending bytes plus "age of the outstanding frame".
  logic [DW-1:0] mq[$];
  bit            m_active, m_acked, m_start, m_ovf, m_err;
  int            m_age;
  logic [DW-1:0] m_data;

  // Busy responder and stimulus knobs.
  bit            force_busy, rand_resp;
  int            bw, bl, resp_dly, resp_len;
  logic [DW-1:0] txlog[$];
  int            n_starts;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_active = 0; m_acked = 0; m_start = 0; m_ovf = 0; m_err = 0;
    m_age = 0; m_data = '0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_edge();
    bit            pop, err_set;
    logic [DW-1:0] head;
    err_set = 0;
    head    = '0;
    pop = !m_active && (mq.size() > 0) && !tx_busy;
    if (m_active) begin
      if (!m_acked) begin
        // Busy during the start cycle itself does not count as an acknowledge.
        if (m_age >= 1 && tx_busy) m_acked = 1;
        else if (m_age == ACK) begin err_set = 1; m_active = 0; end
        m_age++;
      end else if (!tx_busy) begin
        m_active = 0;
      end
    end
    if (pop) head = mq.pop_front();
    if (wr_en) begin
      if (mq.size() < DEPTH) mq.push_back(wr_data);
      else if (!clr) m_ovf = 1;
    end
    if (clr) begin m_ovf = 0; m_err = 0; end
    else if (err_set) m_err = 1;
    m_start = pop;
    if (pop) begin m_data = head; m_active = 1; m_age = 0; m_acked = 0; end
  endtask

  task automatic compare_all();
    chk("count",    32'(count),    32'(mq.size()));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("overflow", 32'(ovf),      32'(m_ovf));
    chk("ack_err",  32'(ack_err),  32'(m_err));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data",  32'(tx_data),  32'(m_data));
  endtask

  // Drive busy, take one edge, advance model and responder, compare at edge+1.
  task automatic step();
    tx_busy = force_busy || (bw == 0 && bl > 0);
    @(posedge clk);
    model_edge();
    if (bw > 0) bw--;
    else if (bl > 0) bl--;
    if (m_start) begin
      if (rand_resp) begin
        resp_dly = $urandom_range(0, 3);
        resp_len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
      end
      bw = resp_dly; bl = resp_len;
    end
    #1;
    compare_all();
    if (tx_start === 1'b1) begin txlog.push_back(tx_data); n_starts++; end
  endtask

  task automatic do_reset();
    wr_en = 0; clr = 0; force_busy = 0; tx_busy = 0;
    rst = 1;
    #1;
    chk("rst_count",    32'(count),    0);
    chk("rst_empty",    32'(empty),    1);
    chk("rst_full",     32'(full),     0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_overflow", 32'(ovf),      0);
    chk("rst_ack_err",  32'(ack_err),  0);
    chk("rst_tx_data",  32'(tx_data),  0);
    model_clear();
    bw = 0; bl = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic write1(input logic [DW-1:0] d);
    wr_en = 1; wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(mq.size() == 0 && !m_active && bw == 0 && bl == 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_errs++;
      $display("FAIL drain_timeout: still busy after %0d cycles", budget);
    end
    step();
  endtask

  initial begin
    int snap;
    rst = 1; wr_en = 0; wr_data = '0; clr = 0; tx_busy = 0;
    force_busy = 0; rand_resp = 0; resp_dly = 0; resp_len = 10; n_starts = 0;
    #2;
    do_reset();

    // Single byte: empty after the write edge clears, start one edge later.
    resp_dly = 0; resp_len = 10;
    write1(8'h56);
    chk("single_empty_after_wr", 32'(empty), 0);
    chk("single_no_start_yet",   32'(tx_start), 0);
    step();
    chk("single_start",   32'(tx_start), 1);
    chk("single_data",    32'(tx_data),  32'h56);
    step();
    chk("single_start_1cyc", 32'(tx_start), 0);
    drain(100);
    chk("single_empty_end", 32'(empty), 1);

    // Burst of 20 behind an externally busy transmitter.
    txlog.delete();
    force_busy = 1; resp_dly = 1; resp_len = 4;
    for (int i = 0; i < 20; i++) write1(DW'(i));
    chk("burst_count",    32'(count), 16);
    chk("burst_full",     32'(full),  1);
    chk("burst_overflow", 32'(ovf),   1);
    force_busy = 0;
    drain(1000);
    for (int i = 0; i < 6; i++) write1(8'hA0 + DW'(i));
    drain(1000);
    chk("burst_log_len", 32'(txlog.size()), 22);
    for (int i = 0; i < 22 && i < txlog.size(); i++)
      chk("burst_order", 32'(txlog[i]), (i < 16) ? i : (32'hA0 + i - 16));

    clr = 1; step(); clr = 0;
    chk("clr_overflow", 32'(ovf), 0);

    // Full FIFO, busy falls, write on the pop edge.
    force_busy = 1;
    for (int i = 0; i < 16; i++) write1(8'h30 + DW'(i));
    chk("fullpop_full_before", 32'(full), 1);
    force_busy = 0; resp_dly = 0; resp_len = 3;
    write1(8'hEE);
    chk("fullpop_count",    32'(count),    16);
    chk("fullpop_overflow", 32'(ovf),      0);
    chk("fullpop_start",    32'(tx_start), 1);
    chk("fullpop_data",     32'(tx_data),  32'h30);
    drain(1000);

    // Ack timeout: responder never raises busy.
    resp_dly = 0; resp_len = 0;
    write1(8'h11);
    write1(8'h22);
    chk("ack_start1", 32'(tx_start), 1);
    chk("ack_data1",  32'(tx_data),  32'h11);
    repeat (8) step();
    chk("ack_err_not_yet", 32'(ack_err), 0);
    step();
    chk("ack_err_set", 32'(ack_err), 1);
    step();
    chk("ack_next_start", 32'(tx_start), 1);
    chk("ack_next_data",  32'(tx_data),  32'h22);
    drain(200);
    clr = 1; step(); clr = 0;
    chk("ack_err_cleared", 32'(ack_err), 0);

    // Clear beats a coincident overflow set.
    resp_dly = 0; resp_len = 3;
    force_busy = 1;
    for (int i = 0; i < 17; i++) write1(DW'(i));
    chk("ovf_set", 32'(ovf), 1);
    wr_en = 1; wr_data = 8'hFF; clr = 1;
    step();
    wr_en = 0; clr = 0;
    chk("clr_beats_set", 32'(ovf), 0);

    // Reset while WAIT_DONE with 3 bytes queued.
    do_reset();
    resp_dly = 1; resp_len = 20;
    for (int i = 0; i < 4; i++) write1(8'h70 + DW'(i));
    step(); step();
    chk("midframe_count_before", 32'(count), 3);
    do_reset();
    // Reset during the start pulse itself.
    write1(8'h99);
    step();
    chk("pulse_before_rst", 32'(tx_start), 1);
    do_reset();
    snap = n_starts;
    repeat (20) step();
    chk("no_start_after_rst", 32'(n_starts - snap), 0);

    // Randomized traffic, random responder, occasional external busy and clears.
    rand_resp = 1;
    for (int blk = 0; blk < 15; blk++) begin
      int pct;
      pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 40 : 90);
      for (int c = 0; c < 200; c++) begin
        wr_en   = ($urandom_range(0, 99) < pct);
        wr_data = DW'($urandom);
        clr     = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 49) == 0) force_busy = !force_busy;
        step();
      end
    end
    wr_en = 0; clr = 0; force_busy = 0;
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
